// File: rtl/sub86_boot_ctl.sv
// Boot loader and reset sequencer for the sub86 core: receives a framed image
// over a byte link, writes it into instruction RAM as 16-bit words, then releases the core.
module sub86_boot_ctl #(
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          TIMEOUT = 1000000,
  parameter int          TO_W    = 20
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic        reload_i,
  output logic [31:0] ima_o,
  output logic [15:0] imq_o,
  output logic        imwen_o,
  output logic        core_rstn_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // state | meaning
  // SYNC  | hunting for the A5 sync byte
  // LENH  | waiting for word count high byte
  // LENL  | waiting for word count low byte
  // DATH  | waiting for first (high) byte of a word
  // DATL  | waiting for second (low) byte of a word
  // WR    | one-cycle RAM write strobe, link stalled
  // CSUM  | waiting for the XOR checksum byte
  // RUN   | image loaded, core released
  typedef enum logic [2:0] {
    S_SYNC, S_LENH, S_LENL, S_DATH, S_DATL, S_WR, S_CSUM, S_RUN
  } state_t;

  localparam logic [TO_W-1:0] GAP_LAST = TO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [31:0]      ima_q, ima_d;
  logic [15:0]      imq_q, imq_d;
  logic [15:0]      count_q, count_d;
  logic [7:0]       csum_q, csum_d;
  logic [TO_W-1:0]  gap_q, gap_d;
  logic             err_q, err_d;
  logic             rx_ready_q, rx_ready_d;
  logic             imwen_q, imwen_d;
  logic             core_rstn_q, core_rstn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             waiting;
  logic [15:0]      full_count;

  always_comb begin
    state_d    = state_q;
    ima_d      = ima_q;
    imq_d      = imq_q;
    count_d    = count_q;
    csum_d     = csum_q;
    gap_d      = gap_q;
    err_d      = err_q;
    // a byte offered alongside RELOAD is never taken
    accept     = rx_valid_i & rx_ready_q & ~reload_i;
    waiting    = (state_q == S_LENH) || (state_q == S_LENL) || (state_q == S_DATH) ||
                 (state_q == S_DATL) || (state_q == S_CSUM);
    full_count = {count_q[15:8], rx_data_i};

    if (reload_i) begin
      state_d = S_SYNC;
      err_d   = 1'b0;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_SYNC: begin
          gap_d = '0;
          if (accept && rx_data_i == 8'hA5) begin
            state_d = S_LENH;
            err_d   = 1'b0;
            csum_d  = 8'h00;
            ima_d   = BASE;
          end
        end
        S_LENH: begin
          if (accept) begin
            count_d[15:8] = rx_data_i;
            state_d       = S_LENL;
          end
        end
        S_LENL: begin
          if (accept) begin
            count_d = full_count;
            state_d = (full_count == 16'h0000) ? S_CSUM : S_DATH;
          end
        end
        S_DATH: begin
          if (accept) begin
            imq_d[15:8] = rx_data_i;
            csum_d      = csum_q ^ rx_data_i;
            state_d     = S_DATL;
          end
        end
        S_DATL: begin
          if (accept) begin
            imq_d[7:0] = rx_data_i;
            csum_d     = csum_q ^ rx_data_i;
            state_d    = S_WR;
          end
        end
        S_WR: begin
          ima_d   = ima_q + 32'd2;
          count_d = count_q - 16'd1;
          state_d = (count_q == 16'd1) ? S_CSUM : S_DATH;
        end
        S_CSUM: begin
          if (accept) begin
            if (rx_data_i == csum_q) begin
              state_d = S_RUN;
            end else begin
              state_d = S_SYNC;
              err_d   = 1'b1;
            end
          end
        end
        S_RUN: begin
          gap_d = '0;
        end
        default: state_d = S_SYNC;
      endcase

      // inter-byte gap watchdog overrides any in-frame transition
      if (waiting) begin
        if (accept) begin
          gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_SYNC;
          err_d   = 1'b1;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + TO_W'(1);
        end
      end
    end

    rx_ready_d  = (state_d != S_WR) && (state_d != S_RUN);
    imwen_d     = (state_d != S_WR);
    core_rstn_d = (state_d == S_RUN);
    done_d      = (state_d == S_RUN);
    busy_d      = (state_d != S_SYNC) && (state_d != S_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_SYNC;
      ima_q       <= BASE;
      imq_q       <= 16'h0000;
      count_q     <= 16'h0000;
      csum_q      <= 8'h00;
      gap_q       <= '0;
      err_q       <= 1'b0;
      rx_ready_q  <= 1'b0;
      imwen_q     <= 1'b1;
      core_rstn_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ima_q       <= ima_d;
      imq_q       <= imq_d;
      count_q     <= count_d;
      csum_q      <= csum_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
      rx_ready_q  <= rx_ready_d;
      imwen_q     <= imwen_d;
      core_rstn_q <= core_rstn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign ima_o       = ima_q;
  assign imq_o       = imq_q;
  assign imwen_o     = imwen_q;
  assign core_rstn_o = core_rstn_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sub86_boot_ctl.sv
// Directed vector bench for sub86_boot_ctl: per-cycle expected outputs from a table,
// plus hand-written timeout and mid-frame reset sequences.
module tb_sub86_boot_ctl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic [31:0] ima;
  logic [15:0] imq;
  logic        imwen;
  logic        core_rstn;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  sub86_boot_ctl #(
    .BASE    (32'h0000_0000),
    .TIMEOUT (16),
    .TO_W    (5)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .reload_i    (reload),
    .ima_o       (ima),
    .imq_o       (imq),
    .imwen_o     (imwen),
    .core_rstn_o (core_rstn),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  // X_BSY covers LENH/LENL/DATH/DATL/CSUM, which share identical Moore outputs
  typedef enum {X_SYNC, X_BSY, X_WR, X_RUN} xst_t;

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        rld;
    xst_t        st;
    logic        er;
    logic [31:0] ima;
    logic [15:0] imq;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic vld, input logic [7:0] dat, input logic rld,
                              input xst_t st, input logic er, input logic [31:0] a,
                              input logic [15:0] q);
    vec_t v;
    v.vld = vld; v.dat = dat; v.rld = rld; v.st = st; v.er = er; v.ima = a; v.imq = q;
    tbl.push_back(v);
  endfunction

  // {rdy, imwen, core_rstn, done, err, busy, ima, imq}
  function automatic logic [63:0] expv(input xst_t st, input logic er,
                                       input logic [31:0] a, input logic [15:0] q);
    logic [5:0] c;
    case (st)
      X_SYNC:  c = {1'b1, 1'b1, 1'b0, 1'b0, er, 1'b0};
      X_BSY:   c = {1'b1, 1'b1, 1'b0, 1'b0, er, 1'b1};
      X_WR:    c = {1'b0, 1'b0, 1'b0, 1'b0, er, 1'b1};
      default: c = {1'b0, 1'b1, 1'b1, 1'b1, er, 1'b0};
    endcase
    return {10'b0, c, a, q};
  endfunction

  function automatic logic [63:0] actv();
    return {10'b0, rx_ready, imwen, core_rstn, done, err, busy, ima, imq};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
  endtask

  initial begin
    int          cycles;
    logic        saw_wen;
    logic [63:0] rst_exp;

    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    rst_exp = {10'b0, 6'b010000, 32'h0, 16'h0};

    // good frame with continuous stream: back-pressure in WR, then RELOAD in RUN
    add(1, 8'hA5, 0, X_BSY,  0, 0, 16'h0000);
    add(1, 8'h00, 0, X_BSY,  0, 0, 16'h0000);
    add(1, 8'h02, 0, X_BSY,  0, 0, 16'h0000);
    add(1, 8'h90, 0, X_BSY,  0, 0, 16'h9000);
    add(1, 8'hE9, 0, X_WR,   0, 0, 16'h90E9);
    add(1, 8'h0F, 0, X_BSY,  0, 2, 16'h90E9);
    add(1, 8'h0F, 0, X_BSY,  0, 2, 16'h0FE9);
    add(1, 8'h8F, 0, X_WR,   0, 2, 16'h0F8F);
    add(1, 8'hF9, 0, X_BSY,  0, 4, 16'h0F8F);
    add(1, 8'hF9, 0, X_RUN,  0, 4, 16'h0F8F);
    add(1, 8'h55, 0, X_RUN,  0, 4, 16'h0F8F);
    add(1, 8'hA5, 1, X_SYNC, 0, 4, 16'h0F8F);
    add(0, 8'h00, 0, X_SYNC, 0, 4, 16'h0F8F);
    // bad checksum
    add(1, 8'hA5, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h00, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h02, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h90, 0, X_BSY,  0, 0, 16'h908F);
    add(1, 8'hE9, 0, X_WR,   0, 0, 16'h90E9);
    add(1, 8'h0F, 0, X_BSY,  0, 2, 16'h90E9);
    add(1, 8'h0F, 0, X_BSY,  0, 2, 16'h0FE9);
    add(1, 8'h8F, 0, X_WR,   0, 2, 16'h0F8F);
    add(1, 8'h00, 0, X_BSY,  0, 4, 16'h0F8F);
    add(1, 8'h00, 0, X_SYNC, 1, 4, 16'h0F8F);
    add(0, 8'h00, 0, X_SYNC, 1, 4, 16'h0F8F);
    // resend good frame: ERR clears on sync byte
    add(1, 8'hA5, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h00, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h02, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h90, 0, X_BSY,  0, 0, 16'h908F);
    add(1, 8'hE9, 0, X_WR,   0, 0, 16'h90E9);
    add(1, 8'h0F, 0, X_BSY,  0, 2, 16'h90E9);
    add(1, 8'h0F, 0, X_BSY,  0, 2, 16'h0FE9);
    add(1, 8'h8F, 0, X_WR,   0, 2, 16'h0F8F);
    add(1, 8'hF9, 0, X_BSY,  0, 4, 16'h0F8F);
    add(1, 8'hF9, 0, X_RUN,  0, 4, 16'h0F8F);
    add(0, 8'h00, 1, X_SYNC, 0, 4, 16'h0F8F);
    // junk then zero-length frame
    add(1, 8'h12, 0, X_SYNC, 0, 4, 16'h0F8F);
    add(1, 8'h34, 0, X_SYNC, 0, 4, 16'h0F8F);
    add(1, 8'hA5, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h00, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h00, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h00, 0, X_RUN,  0, 0, 16'h0F8F);
    add(0, 8'h00, 1, X_SYNC, 0, 0, 16'h0F8F);
    // RELOAD mid-payload with a byte offered the same cycle
    add(1, 8'hA5, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h00, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h01, 0, X_BSY,  0, 0, 16'h0F8F);
    add(1, 8'h90, 0, X_BSY,  0, 0, 16'h908F);
    add(1, 8'hE9, 1, X_SYNC, 0, 0, 16'h908F);
    add(0, 8'h00, 0, X_SYNC, 0, 0, 16'h908F);

    tick();
    tick();
    check("reset", actv(), rst_exp);
    rstn = 1'b1;
    tick();
    check("post-reset idle", actv(), expv(X_SYNC, 0, 0, 16'h0000));

    for (int i = 0; i < tbl.size(); i++) begin
      rx_valid = tbl[i].vld;
      rx_data  = tbl[i].dat;
      reload   = tbl[i].rld;
      tick();
      check($sformatf("vec %0d", i), actv(), expv(tbl[i].st, tbl[i].er, tbl[i].ima, tbl[i].imq));
    end
    reload = 1'b0;

    // gap timeout after the first payload byte
    send(8'hA5); send(8'h00); send(8'h01); send(8'h90);
    check("timeout pre", actv(), expv(X_BSY, 0, 0, 16'h908F));
    rx_valid = 1'b0;
    cycles   = 0;
    saw_wen  = 1'b0;
    while (!err && cycles < 40) begin
      tick();
      cycles++;
      if (!imwen) saw_wen = 1'b1;
    end
    check("timeout cycles", 64'(cycles), 64'd16);
    check("timeout no write", {63'b0, saw_wen}, 64'd0);
    check("timeout outputs", actv(), expv(X_SYNC, 1, 0, 16'h908F));
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload clears err", actv(), expv(X_SYNC, 0, 0, 16'h908F));

    // reset while in DATL with the completing byte on the link
    send(8'hA5); send(8'h00); send(8'h01); send(8'h90);
    rstn     = 1'b0;
    rx_data  = 8'hE9;
    tick();
    check("reset mid-frame", actv(), rst_exp);
    rstn     = 1'b1;
    rx_valid = 1'b0;
    tick();
    check("after reset 1", actv(), expv(X_SYNC, 0, 0, 16'h0000));
    tick();
    check("after reset 2", actv(), expv(X_SYNC, 0, 0, 16'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
